puf_uart_ctrl: RTL

Command sequencer between the UART byte links (UART_RXD / UART_TXD) and the PUF core. It parses host command bytes from the receiver and collects challenge bytes. It launches one PUF evaluation, then serialises a framed response back through the transmitter one byte at a time. It is the only block that drives the transmitter's `tx_DV` and `tx_Byte`.

---
 rtl/puf_uart_pkg.sv | 25 ++
 rtl/puf_uart_timeout.sv | 31 +++
 rtl/puf_uart_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/puf_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puf_uart_pkg
// Description : Command/reply byte codes and sequencer state encoding shared
//               by the PUF UART controller files.
// Revision    : 1.0 - initial release
// ============================================================================
package puf_uart_pkg;

    localparam logic [7:0] CMD_PING = 8'h3F;
    localparam logic [7:0] CMD_CHAL = 8'hC1;
    localparam logic [7:0] RSP_PING = 8'hAB;
    localparam logic [7:0] RSP_HDR  = 8'hA5;
    localparam logic [7:0] RSP_ERR  = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_CHAL = 3'd1,
        ST_PUF_RUN = 3'd2,
        ST_TX_LOAD = 3'd3,
        ST_TX_WAIT = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/puf_uart_timeout.sv
`default_nettype none
// ============================================================================
// Module      : puf_uart_timeout
// Description : 16-bit idle counter with clear; strobes expire while the
//               count sits at the loaded limit and the counter is enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_uart_timeout (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [15:0] i_limit,
    output logic        o_expire
);

    logic [15:0] r_count;

    // Saturates at the limit so a late clear never sees a wrapped count
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= 16'd0;
        end else if (i_en && (r_count != i_limit)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_expire = i_en && !i_clr && (r_count == i_limit);

endmodule
`default_nettype wire

// File: rtl/puf_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : puf_uart_ctrl
// Description : Host command sequencer: parses UART bytes, collects the
//               challenge, runs one PUF evaluation and streams the reply.
// Revision    : 1.0 - initial release
// ============================================================================
module puf_uart_ctrl
    import puf_uart_pkg::*;
#(
    parameter int CHAL_BYTES       = 4,
    parameter int RESP_BYTES       = 4,
    parameter int RX_TIMEOUT_CLKS  = 65535,
    parameter int PUF_TIMEOUT_CLKS = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_dv,
    input  logic [7:0]              rx_byte,
    input  logic                    tx_done,
    input  logic                    tx_active,
    output logic                    tx_dv,
    output logic [7:0]              tx_byte,
    output logic                    puf_start,
    output logic [8*CHAL_BYTES-1:0] puf_challenge,
    input  logic                    puf_done,
    input  logic [8*RESP_BYTES-1:0] puf_response,
    output logic                    busy,
    output logic                    err
);

    localparam int c_chal_w      = 8 * CHAL_BYTES;
    localparam int c_frame_bytes = RESP_BYTES + 1;
    localparam int c_frame_w     = 8 * c_frame_bytes;
    localparam int c_cidx_w      = $clog2(CHAL_BYTES + 1);
    localparam int c_tidx_w      = $clog2(c_frame_bytes + 1);

    localparam logic [c_cidx_w-1:0] c_chal_last  = c_cidx_w'(CHAL_BYTES - 1);
    localparam logic [c_tidx_w-1:0] c_frame_last = c_tidx_w'(c_frame_bytes - 1);
    localparam logic [c_cidx_w-1:0] c_cidx_one   = c_cidx_w'(1);
    localparam logic [c_tidx_w-1:0] c_tidx_one   = c_tidx_w'(1);
    localparam logic [15:0]         c_rx_limit   = 16'(RX_TIMEOUT_CLKS);
    localparam logic [15:0]         c_puf_limit  = 16'(PUF_TIMEOUT_CLKS);
    localparam logic [c_frame_w-9:0] c_pad       = '0;

    state_t                r_state;
    logic [c_cidx_w-1:0]   r_chal_idx;
    logic [c_tidx_w-1:0]   r_tx_idx;
    logic [c_tidx_w-1:0]   r_tx_last;
    logic [c_frame_w-1:0]  r_tx_shift;

    logic w_rx_clr;
    logic w_rx_en;
    logic w_rx_expire;
    logic w_puf_clr;
    logic w_puf_en;
    logic w_puf_expire;

    assign w_rx_en   = (r_state == ST_RX_CHAL);
    assign w_rx_clr  = !w_rx_en || rx_dv;
    assign w_puf_en  = (r_state == ST_PUF_RUN);
    assign w_puf_clr = !w_puf_en;

    puf_uart_timeout u_rx_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_rx_clr),
        .i_en     (w_rx_en),
        .i_limit  (c_rx_limit),
        .o_expire (w_rx_expire)
    );

    puf_uart_timeout u_puf_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_puf_clr),
        .i_en     (w_puf_en),
        .i_limit  (c_puf_limit),
        .o_expire (w_puf_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_chal_idx    <= '0;
            r_tx_idx      <= '0;
            r_tx_last     <= '0;
            r_tx_shift    <= '0;
            tx_dv         <= 1'b0;
            tx_byte       <= 8'h00;
            puf_start     <= 1'b0;
            puf_challenge <= '0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else begin
            tx_dv     <= 1'b0;
            puf_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (rx_dv) begin
                        busy <= 1'b1;
                        if (rx_byte == CMD_CHAL) begin
                            r_chal_idx <= '0;
                            r_state    <= ST_RX_CHAL;
                        end else begin
                            r_tx_idx  <= '0;
                            r_tx_last <= '0;
                            r_state   <= ST_TX_LOAD;
                            if (rx_byte == CMD_PING) begin
                                r_tx_shift <= {RSP_PING, c_pad};
                                err        <= 1'b0;
                            end else begin
                                r_tx_shift <= {RSP_ERR, c_pad};
                                err        <= 1'b1;
                            end
                        end
                    end
                end

                ST_RX_CHAL: begin
                    // A byte arriving on the expiry cycle still counts
                    if (rx_dv) begin
                        puf_challenge[c_chal_w-8-8*int'(r_chal_idx) +: 8] <= rx_byte;
                        if (r_chal_idx == c_chal_last) begin
                            r_chal_idx <= '0;
                            puf_start  <= 1'b1;
                            r_state    <= ST_PUF_RUN;
                        end else begin
                            r_chal_idx <= r_chal_idx + c_cidx_one;
                        end
                    end else if (w_rx_expire) begin
                        puf_challenge <= '0;
                        r_chal_idx    <= '0;
                        r_tx_shift    <= {RSP_ERR, c_pad};
                        r_tx_idx      <= '0;
                        r_tx_last     <= '0;
                        err           <= 1'b1;
                        r_state       <= ST_TX_LOAD;
                    end
                end

                ST_PUF_RUN: begin
                    // puf_done coincident with our own start strobe is stale
                    if (puf_done && !puf_start) begin
                        r_tx_shift <= {RSP_HDR, puf_response};
                        r_tx_idx   <= '0;
                        r_tx_last  <= c_frame_last;
                        r_state    <= ST_TX_LOAD;
                    end else if (w_puf_expire) begin
                        r_tx_shift <= {RSP_ERR, c_pad};
                        r_tx_idx   <= '0;
                        r_tx_last  <= '0;
                        err        <= 1'b1;
                        r_state    <= ST_TX_LOAD;
                    end
                end

                ST_TX_LOAD: begin
                    if (!tx_active) begin
                        tx_dv   <= 1'b1;
                        tx_byte <= r_tx_shift[c_frame_w-1 -: 8];
                        r_state <= ST_TX_WAIT;
                    end
                end

                ST_TX_WAIT: begin
                    if (tx_done) begin
                        if (r_tx_idx != r_tx_last) begin
                            r_tx_idx   <= r_tx_idx + c_tidx_one;
                            r_tx_shift <= r_tx_shift << 8;
                            r_state    <= ST_TX_LOAD;
                        end else begin
                            busy    <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
